raster_scan_ctrl: RTL and testbench
===================================

Name: raster_scan_ctrl

Overview:
- Sequences the pixel raster for the 640x480 VGA display on the Basys 3.
- Produces the Xcoordinate/Ycoordinate scan, sync and blanking signals consumed by the line and cell drawing logic.
- Tracks the grid band and horizontal-line position incrementally, so downstream overlay logic needs no wide comparators.
- Start/stop is frame-aligned: the display never truncates a frame.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz)
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing in pixels (H_TOTAL = 800)
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing in lines (V_TOTAL = 525)
- GRID_Y0, 78, Y of first horizontal grid line
- GRID_PITCH, 50, line-to-line spacing
- GRID_ROWS, 7, number of horizontal lines
- LINE_W, 9, line thickness in rows
- GRID_XMIN, 8, exclusive left bound of line span
- GRID_XMAX, 631, exclusive right bound of line span

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  level request to scan
- busy  out  1  high when the state is not STOP
- pix_en  out  1  one-clk pixel strobe
- Xcoordinate  out  16  current pixel column
- Ycoordinate  out  16  current pixel row
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- active  out  1  pixel is inside the 640x480 visible area
- line_end  out  1  one-clk pulse on the last pixel of a line
- frame_start  out  1  one-clk pulse on pixel (0,0)
- grid_row  out  3  count of grid lines whose first row has been reached in this frame (0..GRID_ROWS)
- on_hline  out  1  current pixel lies on a horizontal grid line

Behaviour:
- Reset (async, immediate with no clock edge required):
  - State goes to STOP; div_cnt, X, Y and grid_row go to 0; threshold goes to GRID_Y0.
  - Outputs: busy=0, pix_en=0, hsync=1, vsync=1, active=0, line_end=0, frame_start=0, on_hline=0.
- FSM states: STOP, RUN, DRAIN.
  - STOP -> RUN when run=1 at a clk edge.
  - RUN -> DRAIN when run=0.
  - DRAIN -> RUN when run=1; the scan is not interrupted.
  - DRAIN -> STOP on the clk where pix_en=1, X=H_TOTAL-1 and Y=V_TOTAL-1; X and Y wrap to 0 on that edge.
  - In STOP, counters hold at 0 and outputs hold at their reset values.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while in RUN or DRAIN; it is 0 on the first RUN cycle.
  - pix_en = (div_cnt == CLK_DIV-1) and state != STOP.
  - The first pix_en occurs on the 4th clk after entering RUN.
- Counters advance only on pix_en:
  - X increments; X = H_TOTAL-1 wraps to 0 and increments Y.
  - Y = V_TOTAL-1 wraps to 0.
  - 16-bit unsigned arithmetic, with no values outside the totals.
- Decodes are combinational from the registered X and Y (zero latency):
  - active = X < H_ACTIVE and Y < V_ACTIVE.
  - hsync = 0 for X in 656..751; vsync = 0 for Y in 490..491.
  - line_end = pix_en and X = 799.
  - frame_start = pix_en and X = 0 and Y = 0, asserted only when busy.
- Grid tracker (registered, updated on pix_en at line wrap):
  - If the new Y equals the threshold and grid_row < GRID_ROWS: grid_row increments and threshold += GRID_PITCH.
  - At frame wrap: grid_row = 0 and threshold = GRID_Y0.
  - The tracker saturates at GRID_ROWS; the threshold is not advanced past the last line.
  - on_hline = grid_row > 0 and Y <= (GRID_Y0 + (grid_row-1)*GRID_PITCH + LINE_W - 1) and GRID_XMIN < X < GRID_XMAX.
  - The subtraction is held as a registered line-top value updated together with grid_row, not multiplied.
- Simultaneous events:
  - run falling on the same clk as the frame wrap while in RUN: go to DRAIN; a full further frame is scanned.
  - reset overrides everything.
  - A run glitch in STOP that lasts one clk still starts a frame.

Test Plan:
- Reset, then run=1 at cycle 0 -> busy=1 at cycle 1; pix_en pulses at cycles 4, 8, 12...; X=1 after the first pix_en; hsync=vsync=1, active=1 at (0,0).
- Run one full line -> hsync low for exactly 96 pix_en periods starting at X=656; line_end once at X=799; Y 0->1 and X 799->0 on the same edge; active=0 for X >= 640.
- Run one full frame -> vsync low only on Y=490 and 491; frame_start exactly once per 1,680,000 clks; Y wraps 524->0.
- Grid scan -> grid_row=0 for Y<78, 1 at Y=78, 2 at Y=128, 7 at Y>=378 to frame end. on_hline=1 for X=9..630 on Y=78..86 and 378..386; on_hline=0 at X=8, X=631, Y=87 and Y=127; grid_row=0 after the wrap.
- Drop run at Y=200 -> busy stays 1 and the scan continues; STOP after X=799,Y=524 with X=Y=0 and hsync=vsync=1. Repeat, reasserting run at Y=400 -> no STOP; the next frame_start occurs on schedule.
- Assert reset asynchronously mid-line at X=300, Y=100 -> all outputs reach reset values before the next clk edge. After release with run=1, the scan restarts from (0,0).

Source files
------------

// File: rtl/raster_scan_ctrl.sv
// rtl/raster_scan_ctrl.sv - VGA raster sequencer with frame-aligned start/stop and grid tracking
module raster_scan_ctrl #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int GRID_Y0    = 78,
  parameter int GRID_PITCH = 50,
  parameter int GRID_ROWS  = 7,
  parameter int LINE_W     = 9,
  parameter int GRID_XMIN  = 8,
  parameter int GRID_XMAX  = 631
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        busy,
  output logic        pix_en,
  output logic [15:0] Xcoordinate,
  output logic [15:0] Ycoordinate,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        line_end,
  output logic        frame_start,
  output logic [2:0]  grid_row,
  output logic        on_hline
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [15:0] X_LAST   = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] Y_LAST   = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] X_ACT    = 16'(H_ACTIVE);
  localparam logic [15:0] Y_ACT    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_FIRST = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_LAST  = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [15:0] VS_FIRST = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_LAST  = 16'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [15:0] G_Y0     = 16'(GRID_Y0);
  localparam logic [15:0] G_PITCH  = 16'(GRID_PITCH);
  localparam logic [15:0] G_BOTTOM = 16'(LINE_W - 1);
  localparam logic [15:0] G_XMIN   = 16'(GRID_XMIN);
  localparam logic [15:0] G_XMAX   = 16'(GRID_XMAX);
  localparam logic [2:0]  G_ROWS   = 3'(GRID_ROWS);

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [15:0]      x_q, x_d;
  logic [15:0]      y_q, y_d;
  logic [2:0]       grid_row_q, grid_row_d;
  logic [15:0]      thresh_q, thresh_d;
  logic [15:0]      line_top_q, line_top_d;
  logic             line_wrap;
  logic             frame_wrap;

  // Pixel strobe and the line/frame wrap events it qualifies
  always_comb begin
    busy       = (state_q != ST_STOP);
    pix_en     = busy && (div_q == DIV_LAST);
    line_wrap  = pix_en && (x_q == X_LAST);
    frame_wrap = line_wrap && (y_q == Y_LAST);
  end

  // Run/drain sequencing; a drain only ends on a completed frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP:  if (run) state_d = ST_RUN;
      ST_RUN:   if (!run) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (run)             state_d = ST_RUN;
        else if (frame_wrap) state_d = ST_STOP;
      end
      default:  state_d = ST_STOP;
    endcase
  end

  // Clock divider and X/Y scan counters; everything sits at zero while stopped
  always_comb begin
    div_d = '0;
    if (busy && (div_q != DIV_LAST)) div_d = div_q + DIV_W'(1);
    x_d = x_q;
    y_d = y_q;
    if (line_wrap) begin
      x_d = '0;
      y_d = (y_q == Y_LAST) ? '0 : y_q + 16'd1;
    end else if (pix_en) begin
      x_d = x_q + 16'd1;
    end
  end

  // Grid tracker: compare the incoming row against the next line top only
  always_comb begin
    grid_row_d = grid_row_q;
    thresh_d   = thresh_q;
    line_top_d = line_top_q;
    if (frame_wrap) begin
      grid_row_d = '0;
      thresh_d   = G_Y0;
      line_top_d = '0;
    end else if (line_wrap && (y_d == thresh_q) && (grid_row_q < G_ROWS)) begin
      grid_row_d = grid_row_q + 3'd1;
      line_top_d = thresh_q;
      if (grid_row_q < (G_ROWS - 3'd1)) thresh_d = thresh_q + G_PITCH;
    end
  end

  // Zero-latency decodes from the registered position
  always_comb begin
    Xcoordinate = x_q;
    Ycoordinate = y_q;
    active      = busy && (x_q < X_ACT) && (y_q < Y_ACT);
    hsync       = !((x_q >= HS_FIRST) && (x_q <= HS_LAST));
    vsync       = !((y_q >= VS_FIRST) && (y_q <= VS_LAST));
    line_end    = line_wrap;
    frame_start = pix_en && (x_q == 16'd0) && (y_q == 16'd0);
    grid_row    = grid_row_q;
    on_hline    = (grid_row_q != 3'd0) && (y_q <= line_top_q + G_BOTTOM) &&
                  (x_q > G_XMIN) && (x_q < G_XMAX);
  end

  // State registers with immediate reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_STOP;
      div_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      grid_row_q <= '0;
      thresh_q   <= G_Y0;
      line_top_q <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      x_q        <= x_d;
      y_q        <= y_d;
      grid_row_q <= grid_row_d;
      thresh_q   <= thresh_d;
      line_top_q <= line_top_d;
    end
  end

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// tb/tb_raster_scan_ctrl.sv - randomized run-level bench against a pixel-count reference model
module tb_raster_scan_ctrl;

  localparam int CD = 4;
  localparam int HA = 16, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 12, VFP = 1, VS = 2, VBP = 2;
  localparam int GY0 = 2, GP = 3, GR = 3, LW = 2, GXMIN = 1, GXMAX = 14;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int TOTAL = HT * VT;
  localparam int FRAME = TOTAL * CD;

  logic clk = 1'b0;
  logic reset;
  logic run;
  logic busy, pix_en, hsync, vsync, active, line_end, frame_start, on_hline;
  logic [15:0] Xcoordinate, Ycoordinate;
  logic [2:0] grid_row;

  int checks = 0;
  int errors = 0;

  bit m_busy, m_drain;
  int m_phase, m_pix;

  raster_scan_ctrl #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .GRID_Y0(GY0), .GRID_PITCH(GP), .GRID_ROWS(GR), .LINE_W(LW),
    .GRID_XMIN(GXMIN), .GRID_XMAX(GXMAX)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .busy(busy), .pix_en(pix_en),
    .Xcoordinate(Xcoordinate), .Ycoordinate(Ycoordinate), .hsync(hsync),
    .vsync(vsync), .active(active), .line_end(line_end),
    .frame_start(frame_start), .grid_row(grid_row), .on_hline(on_hline)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int exp_grid(input int y);
    int c;
    c = 0;
    for (int k = 0; k < GR; k++) if (y >= GY0 + k * GP) c++;
    return c;
  endfunction

  function automatic bit exp_hline(input int x, input int y);
    for (int k = 0; k < GR; k++)
      if (y >= GY0 + k * GP && y <= GY0 + k * GP + LW - 1 && x > GXMIN && x < GXMAX)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_drain = 0; m_phase = 0; m_pix = 0;
  endtask

  task automatic model_step(input bit r);
    bit pe;
    bit last;
    pe = m_busy && (m_phase == CD - 1);
    last = pe && (m_pix == TOTAL - 1);
    if (!m_busy) begin
      if (r) begin m_busy = 1; m_drain = 0; m_phase = 0; m_pix = 0; end
    end else if (m_drain && !r && last) begin
      model_reset();
    end else begin
      m_phase = (m_phase + 1) % CD;
      if (pe) m_pix = (m_pix + 1) % TOTAL;
      m_drain = !r;
    end
  endtask

  task automatic compare_all();
    int x, y;
    bit pe;
    x = m_pix % HT;
    y = m_pix / HT;
    pe = m_busy && (m_phase == CD - 1);
    check("busy", busy, m_busy);
    check("pix_en", pix_en, pe);
    check("x", Xcoordinate, x);
    check("y", Ycoordinate, y);
    check("hsync", hsync, !(x >= HA + HFP && x < HA + HFP + HS));
    check("vsync", vsync, !(y >= VA + VFP && y < VA + VFP + VS));
    check("active", active, m_busy && x < HA && y < VA);
    check("line_end", line_end, pe && x == HT - 1);
    check("frame_start", frame_start, pe && m_pix == 0);
    check("grid_row", grid_row, m_busy ? exp_grid(y) : 0);
    check("on_hline", on_hline, m_busy && exp_hline(x, y));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pix_en"}, pix_en, 0);
    check({tag, "_x"}, Xcoordinate, 0);
    check({tag, "_y"}, Ycoordinate, 0);
    check({tag, "_hsync"}, hsync, 1);
    check({tag, "_vsync"}, vsync, 1);
    check({tag, "_active"}, active, 0);
    check({tag, "_line_end"}, line_end, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_grid_row"}, grid_row, 0);
    check({tag, "_on_hline"}, on_hline, 0);
  endtask

  task automatic cycle(input bit r);
    run = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    compare_all();
  endtask

  // Called right after a negedge; reset lands between clock edges
  task automatic async_reset_mid();
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("async_rst");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    compare_all();
  endtask

  initial begin
    int n;
    int len;
    bit r;
    reset = 1'b1;
    run = 1'b0;
    #1;
    check_reset_state("por");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    compare_all();

    // Start-up latency and first pixel strobe
    cycle(1);
    check("first_busy", busy, 1);
    check("first_pix_en_low", pix_en, 0);
    repeat (3) cycle(1);
    check("fourth_clk_pix_en", pix_en, 1);
    cycle(1);
    check("x_after_first_pix", Xcoordinate, 1);

    // Drop run exactly on the frame-wrap edge: a full extra frame follows
    n = 0;
    while (!(m_busy && m_phase == CD - 1 && m_pix == TOTAL - 1) && n < 2 * FRAME) begin
      cycle(1);
      n++;
    end
    check("reach_wrap", n < 2 * FRAME, 1);
    cycle(0);
    check("drain_after_wrap", busy, 1);
    repeat (FRAME - 8) cycle(0);
    check("still_draining", busy, 1);
    repeat (16) cycle(0);
    check("stopped_after_drain", busy, 0);

    // Single-clock run glitch in STOP starts a whole frame
    cycle(1);
    check("glitch_busy", busy, 1);
    repeat (FRAME / 2) cycle(0);
    check("glitch_running", busy, 1);
    repeat (FRAME / 2 + 8) cycle(0);
    check("glitch_stopped", busy, 0);

    // Async reset in the middle of a scan, then restart from (0,0)
    repeat (FRAME / 3 + $urandom_range(0, 200)) cycle(1);
    async_reset_mid();
    cycle(1);
    check("restart_busy", busy, 1);
    check("restart_x", Xcoordinate, 0);

    // Randomized run-level segments checked every clock against the model
    for (int seg = 0; seg < 24; seg++) begin
      r = seg[0] ? 1'b0 : 1'b1;
      case ($urandom_range(0, 3))
        0:       len = 1;
        1:       len = $urandom_range(2, 60);
        default: len = $urandom_range(FRAME / 2, 2 * FRAME);
      endcase
      repeat (len) cycle(r);
      if (seg % 7 == 3) async_reset_mid();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
